cpu_param: RTL and testbench

- Parametrised successor to the team's fixed 3-bit-PC / 5-bit-datapath CPU core.
- Generalised in data width, PC/instruction-memory depth and register count.
- Adds a start/halt run-control FSM, synchronous reset, registered flags and a richer ISA: immediates, shifts, compare, carry/sign/zero conditional jumps and HALT.
- Instruction memory is internal and loaded through a write port; register contents are observable through a debug read port.

---
 rtl/cpu_param.sv | 169 ++++++++++++++++
 tb/tb_cpu_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_param.sv
// Parametrised multi-cycle CPU core: FETCH/EXEC run-control FSM, internal program memory,
// register file with debug read port and registered carry/zero/sign flags.
module cpu_param #(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 4,
   parameter int REG_AW  = 2,
   parameter int INSTR_W = 4 + 2*REG_AW + DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               run_en,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_wdata,
   input  logic [REG_AW-1:0]  dbg_raddr,
   output logic [DATA_W-1:0]  dbg_rdata,
   output logic [PC_W-1:0]    pc,
   output logic               cf,
   output logic               zf,
   output logic               sf,
   output logic               busy,
   output logic               halted,
   output logic               instr_done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

   localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND  = 4'h3,
                          OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LDI = 4'h7,
                          OP_SHL  = 4'h8, OP_SHR = 4'h9, OP_JMP = 4'hA, OP_JZ   = 4'hB,
                          OP_JN   = 4'hC, OP_JC  = 4'hD, OP_CMP = 4'hE, OP_HALT = 4'hF;
   localparam logic [PC_W-1:0] PC_ONE = 1;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic                cf_q, cf_d, zf_q, zf_d, sf_q, sf_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   regs_q [2**REG_AW];
   logic [INSTR_W-1:0]  imem [2**PC_W];

   logic [3:0]          opcode;
   logic [REG_AW-1:0]   rd, rs;
   logic [DATA_W-1:0]   imm, src_a, src_b, add_b;
   logic [DATA_W:0]     sum, diff;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c, alu_wr, alu_fl, jump_take, wr_en;

   assign opcode = ir_q[INSTR_W-1 -: 4];
   assign rd     = ir_q[INSTR_W-5 -: REG_AW];
   assign rs     = ir_q[DATA_W +: REG_AW];
   assign imm    = ir_q[DATA_W-1:0];
   assign src_a  = regs_q[rd];
   assign src_b  = regs_q[rs];
   assign add_b  = (opcode == OP_ADDI) ? imm : src_b;
   assign sum    = {1'b0, src_a} + {1'b0, add_b};
   // Bit DATA_W of the zero-extended difference is the unsigned borrow (src_a < src_b).
   assign diff   = {1'b0, src_a} - {1'b0, src_b};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_wr    = 1'b0;
      alu_fl    = 1'b0;
      jump_take = 1'b0;
      case (opcode)
         OP_ADD, OP_ADDI: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_SUB:          begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_CMP:          begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_fl = 1'b1; end
         OP_AND:          begin alu_res = src_a & src_b; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_OR:           begin alu_res = src_a | src_b; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_XOR:          begin alu_res = src_a ^ src_b; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_LDI:          begin alu_res = imm; alu_wr = 1'b1; end
         OP_SHL:          begin alu_res = {src_a[DATA_W-2:0], 1'b0}; alu_c = src_a[DATA_W-1]; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_SHR:          begin alu_res = {1'b0, src_a[DATA_W-1:1]}; alu_c = src_a[0];        alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_JMP:          jump_take = 1'b1;
         OP_JZ:           jump_take = zf_q;
         OP_JN:           jump_take = sf_q;
         OP_JC:           jump_take = cf_q;
         default:         ; // NOP and HALT have no datapath effect
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cf_d    = cf_q;
      zf_d    = zf_q;
      sf_d    = sf_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = '0;
               cf_d    = 1'b0;
               zf_d    = 1'b0;
               sf_d    = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (run_en) begin
               ir_d    = imem[pc_q];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (run_en) begin
               done_d = 1'b1;
               wr_en  = alu_wr;
               if (alu_fl) begin
                  cf_d = alu_c;
                  zf_d = (alu_res == '0);
                  sf_d = alu_res[DATA_W-1];
               end
               if (opcode == OP_HALT) begin
                  state_d = S_HALTED;
               end else begin
                  pc_d    = jump_take ? imm[PC_W-1:0] : pc_q + PC_ONE;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         sf_q    <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cf_q    <= cf_d;
         zf_q    <= zf_d;
         sf_q    <= sf_d;
         done_q  <= done_d;
         if (wr_en) regs_q[rd] <= alu_res;
      end
   end

   // NOTE: program memory is deliberately not reset, so a loaded program survives rst_n.
   always_ff @(posedge clk) begin
      if (prog_we) imem[prog_addr] <= prog_wdata;
   end

   assign dbg_rdata  = regs_q[dbg_raddr];
   assign pc         = pc_q;
   assign cf         = cf_q;
   assign zf         = zf_q;
   assign sf         = sf_q;
   assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign halted     = (state_q == S_HALTED);
   assign instr_done = done_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: small hand-assembled programs with hand-computed results,
// cycle counts and instr_done pulse counts.
module tb_cpu_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        run_en = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [15:0] prog_wdata = '0;
   logic [1:0]  dbg_raddr = '0;
   logic [7:0]  dbg_rdata;
   logic [3:0]  pc;
   logic        cf, zf, sf, busy, halted, instr_done;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   cpu_param dut (
      .clk(clk), .rst_n(rst_n), .start(start), .run_en(run_en),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
      .cf(cf), .zf(zf), .sf(sf), .busy(busy), .halted(halted), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] w);
      prog_we = 1'b1; prog_addr = a; prog_wdata = w;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b1;
      tick(); tick();
      rst_n = 1'b1; start = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (!halted && cyc < budget) begin
         tick();
         cyc++;
      end
      if (!halted) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic reg_is(input string tag, input logic [1:0] r, input logic [7:0] exp);
      dbg_raddr = r;
      #1;
      check(tag, dbg_rdata, exp);
   endtask

   task automatic load_add_prog();
      load(0, enc(4'h7, 0, 0, 8'd200));
      load(1, enc(4'h7, 1, 0, 8'd100));
      load(2, enc(4'h1, 0, 1, 8'd0));
      load(3, enc(4'hF, 0, 0, 8'd0));
   endtask

   initial begin
      int cyc, d0;

      // Reset with start held high
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_pc", pc, 0);
      check("rst_flags", {cf, zf, sf}, 0);
      check("rst_done", instr_done, 0);
      for (int r = 0; r < 4; r++) reg_is($sformatf("rst_r%0d", r), 2'(r), 8'd0);

      // Add with carry: 200 + 100 = 300 -> 44, carry out
      load_add_prog();
      d0 = done_cnt;
      start_run();
      check("add_busy", busy, 1);
      wait_halt("add", 100, cyc);
      check("add_cycles", cyc, 8);
      tick();
      check("add_pulses", done_cnt - d0, 4);
      check("add_pc", pc, 3);
      check("add_flags_czs", {cf, zf, sf}, 3'b100);
      reg_is("add_r0", 0, 8'd44);
      reg_is("add_r1", 1, 8'd100);

      // Countdown loop using SUB / JZ / JMP
      load(0, enc(4'h7, 2, 0, 8'd3));
      load(1, enc(4'h7, 3, 0, 8'd1));
      load(2, enc(4'h2, 2, 3, 8'd0));
      load(3, enc(4'hB, 0, 0, 8'd5));
      load(4, enc(4'hA, 0, 0, 8'd2));
      load(5, enc(4'hF, 0, 0, 8'd0));
      d0 = done_cnt;
      start_run();
      wait_halt("loop", 200, cyc);
      check("loop_cycles", cyc, 22);
      tick();
      check("loop_pulses", done_cnt - d0, 11);
      check("loop_pc", pc, 5);
      check("loop_flags_czs", {cf, zf, sf}, 3'b010);
      reg_is("loop_r2", 2, 8'd0);

      // Same loop with a 5-cycle stall while the first JZ is in EXEC
      d0 = done_cnt;
      start_run();
      for (int i = 0; i < 7; i++) tick();
      check("stall_pre_pc", pc, 3);
      run_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("stall%0d_pc", i), pc, 3);
         check($sformatf("stall%0d_busy", i), busy, 1);
         check($sformatf("stall%0d_done", i), instr_done, 0);
         reg_is($sformatf("stall%0d_r2", i), 2, 8'd2);
      end
      check("stall_flags_czs", {cf, zf, sf}, 3'b000);
      run_en = 1'b1;
      wait_halt("stall", 200, cyc);
      check("stall_total_cycles", cyc + 12, 27);
      tick();
      check("stall_pulses", done_cnt - d0, 11);
      reg_is("stall_r2", 2, 8'd0);
      check("stall_zf", zf, 1);

      // PC wrap: 0 ADDI r0,1 ; 1 JMP 15 ; 15 NOP, then HALT patched into 15 while running
      do_reset();
      load(0, enc(4'h6, 0, 0, 8'd1));
      load(1, enc(4'hA, 0, 0, 8'd15));
      load(15, enc(4'h0, 0, 0, 8'd0));
      start_run();
      check("wrap_pc0", pc, 0);
      tick(); tick(); check("wrap_pc1", pc, 1);
      tick(); tick(); check("wrap_pc2", pc, 15);
      tick(); tick(); check("wrap_pc3", pc, 0);
      tick(); tick(); check("wrap_pc4", pc, 1);
      reg_is("wrap_r0", 0, 8'd2);
      load(15, enc(4'hF, 0, 0, 8'd0));
      wait_halt("wrap", 50, cyc);
      check("wrap_halt_cycles", cyc, 3);
      check("wrap_halt_pc", pc, 15);
      reg_is("wrap_r0_final", 0, 8'd2);

      // Reset during EXEC of ADD; program memory must survive
      load_add_prog();
      start_run();
      for (int i = 0; i < 5; i++) tick();
      check("mrst_in_exec_pc", pc, 2);
      do_reset();
      reg_is("mrst_r0", 0, 8'd0);
      reg_is("mrst_r1", 1, 8'd0);
      check("mrst_flags", {cf, zf, sf}, 0);
      check("mrst_busy_halted", {busy, halted}, 0);
      start_run();
      wait_halt("mrst", 100, cyc);
      check("mrst_cycles", cyc, 8);
      reg_is("mrst_r0_rerun", 0, 8'd44);
      check("mrst_cf", cf, 1);

      // Shifts, JC, CMP with borrow, JN, XOR with rd==rs
      load(0,  enc(4'h7, 1, 0, 8'h81));
      load(1,  enc(4'h8, 1, 0, 8'd0));
      load(2,  enc(4'hD, 0, 0, 8'd4));
      load(3,  enc(4'hF, 0, 0, 8'd0));
      load(4,  enc(4'h9, 1, 0, 8'd0));
      load(5,  enc(4'h7, 2, 0, 8'd5));
      load(6,  enc(4'hE, 1, 2, 8'd0));
      load(7,  enc(4'hC, 0, 0, 8'd9));
      load(8,  enc(4'hF, 0, 0, 8'd0));
      load(9,  enc(4'h5, 2, 2, 8'd0));
      load(10, enc(4'hF, 0, 0, 8'd0));
      d0 = done_cnt;
      start_run();
      wait_halt("ops", 100, cyc);
      check("ops_cycles", cyc, 18);
      tick();
      check("ops_pulses", done_cnt - d0, 9);
      check("ops_pc", pc, 10);
      reg_is("ops_r1", 1, 8'h01);
      reg_is("ops_r2", 2, 8'h00);
      check("ops_flags_czs", {cf, zf, sf}, 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
